fir_tap_sequencer: RTL

- Autonomous N-tap dot-product sequencer for the DSP core's MAC datapath.
- Walks a circular sample buffer in data memory A and a coefficient table in data memory B.
- Drives read addresses, mac_clr and mac_en; captures, scales and saturates the accumulator into a DATA_W result.
- Sits beside control_unit. Memory access is gated by a grant from the memory arbiter, so the core and the sequencer can share the memories.

---
 rtl/fir_tap_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: autonomous N-tap dot-product sequencer driving a shared-memory MAC datapath
module fir_tap_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int BUF_LOG2 = 5,
    parameter int MAC_LAT  = 1,
    parameter int SHIFT    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   num_taps,
    input  logic [ADDR_W-1:0]   samp_base,
    input  logic [BUF_LOG2-1:0] samp_head,
    input  logic [ADDR_W-1:0]   coef_base,
    input  logic                mem_gnt,
    input  logic [ACC_W-1:0]    mac_acc,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [ADDR_W-1:0]   addr_b,
    output logic                mac_clr,
    output logic                mac_en,
    output logic                busy,
    output logic [DATA_W-1:0]   result,
    output logic                sat,
    output logic                done,
    output logic                err
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE} state_t;
    localparam int CW = $clog2(MAC_LAT + 2);
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;
    state_t state, next_state;
    logic [ADDR_W-1:0] idx, n_q, samp_base_q, coef_base_q;
    logic [BUF_LOG2-1:0] head_q, off;
    logic [CW-1:0] cnt;
    logic signed [ACC_W-1:0] t;
    logic go, load, acc_ok, hi, lo;

    assign go = state == IDLE && start && !abort;
    assign load = go && num_taps != '0;
    assign acc_ok = state == RUN && mem_gnt;
    assign off = head_q - idx[BUF_LOG2-1:0];
    assign addr_a = samp_base_q + ADDR_W'(off);
    assign addr_b = coef_base_q + idx;
    assign rd_req = state == RUN;
    assign busy = state != IDLE;
    assign t = $signed(mac_acc) >>> SHIFT;
    assign hi = t > S_MAX;
    assign lo = t < S_MIN;

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;

    // Next state: abort beats everything; RUN only advances on granted reads
    always_comb begin
        next_state = state;
        if (abort) next_state = IDLE;
        else
            case (state)
                IDLE:    if (start && num_taps != '0) next_state = CLEAR;
                CLEAR:   next_state = RUN;
                RUN:     if (mem_gnt && idx == n_q - ADDR_W'(1)) next_state = DRAIN;
                DRAIN:   if (cnt == CW'(MAC_LAT)) next_state = CAPTURE;
                CAPTURE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
    end

    // Configuration latch, tap index, drain counter and registered pulses
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            n_q         <= '0;
            samp_base_q <= '0;
            head_q      <= '0;
            coef_base_q <= '0;
            idx         <= '0;
            cnt         <= '0;
            mac_clr     <= 1'b0;
            mac_en      <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (load) begin
                n_q         <= num_taps;
                samp_base_q <= samp_base;
                head_q      <= samp_head;
                coef_base_q <= coef_base;
            end
            idx     <= state == CLEAR ? '0 : acc_ok ? idx + ADDR_W'(1) : idx;
            cnt     <= state == DRAIN ? cnt + CW'(1) : '0;
            mac_clr <= load;
            mac_en  <= acc_ok && !abort;
            err     <= go && num_taps == '0;
            done    <= state == CAPTURE && !abort;
        end

    // Scale and saturate the accumulator on capture; hold otherwise
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            result <= '0;
            sat    <= 1'b0;
        end else if (state == CAPTURE && !abort) begin
            result <= hi ? {1'b0, {(DATA_W-1){1'b1}}} : lo ? {1'b1, {(DATA_W-1){1'b0}}} : t[DATA_W-1:0];
            sat    <= hi || lo;
        end
endmodule
